// File: rtl/enc_pkg.sv
// Shared definitions for the encoder dense-layer sequencer.
// Holds the sequencer state encoding, the Q8.8 fixed-point constants used by
// fixed_point_multiply / fixed_point_add, and a helper that sizes counters.
package enc_pkg;

    // Sequencer states: IDLE=0, MAC=1, BIAS=2, DONE=3
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        BIAS = 2'd2,
        DONE = 2'd3
    } state_e;

    // Q8.8 format: 8 fractional bits, 1.0 = 16'h0100
    localparam int          FRAC_BITS = 8;
    localparam logic [15:0] ONE       = 16'h0100;

    // Width of an index counter covering 0..n-1, never narrower than one bit
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_mac_unit.sv
// Combinational multiply-accumulate slice shared by every output of the
// sequencer: result = add(mul(a, b), c).
// Ports:
//   a      in  BITSIZE  multiplicand
//   b      in  BITSIZE  multiplier
//   c      in  BITSIZE  addend (running accumulator)
//   result out BITSIZE  a*b + c in fixed point
module enc_mac_unit #(
    parameter int BITSIZE = 16
) (
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    input  logic [BITSIZE-1:0] c,
    output logic [BITSIZE-1:0] result
);

    logic [BITSIZE-1:0] product;

    fixed_point_multiply #(.BITSIZE(BITSIZE)) u_mul (
        .a      (a),
        .b      (b),
        .result (product)
    );

    fixed_point_add #(.BITSIZE(BITSIZE)) u_add (
        .a      (product),
        .b      (c),
        .result (result)
    );

endmodule

// File: rtl/fixed_point_add.sv
// Fixed-point adder. Two's-complement addition modulo 2^BITSIZE; overflow
// wraps, there is no saturation.
// Ports:
//   a      in  BITSIZE  first addend
//   b      in  BITSIZE  second addend
//   result out BITSIZE  a+b (wrapped)
module fixed_point_add #(
    parameter int BITSIZE = 16
) (
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    output logic [BITSIZE-1:0] result
);

    assign result = a + b;

endmodule

// File: rtl/fixed_point_multiply.sv
// Signed fixed-point multiplier (Q8.8 with the default width).
// The full-width signed product is shifted right by FRAC_BITS (arithmetic,
// i.e. rounding toward minus infinity) and truncated to BITSIZE bits, so an
// out-of-range product wraps rather than saturates.
// Ports:
//   a      in  BITSIZE  multiplicand
//   b      in  BITSIZE  multiplier
//   result out BITSIZE  a*b in the same fixed-point format
module fixed_point_multiply
    import enc_pkg::*;
#(
    parameter int BITSIZE = 16
) (
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    output logic [BITSIZE-1:0] result
);

    logic signed [2*BITSIZE-1:0] product;

    // Both operands are sign-extended to the product width before multiplying
    assign product = (2*BITSIZE)'($signed(a)) * (2*BITSIZE)'($signed(b));
    assign result  = BITSIZE'(product >>> FRAC_BITS);

endmodule

// File: rtl/enc_mac_sequencer.sv
// Time-multiplexed dense layer y = W*x + b for the encoder path.
// One shared MAC slice is stepped through every (output j, input i) pair;
// each output finishes with one bias cycle that writes y_j.
// Ports:
//   clk    in  1                    rising-edge clock
//   reset  in  1                    synchronous active-high reset
//   start  in  1                    run request, taken only in IDLE
//   x      in  BITSIZE*N_IN         input vector, element i at [i*BITSIZE +: BITSIZE]
//   w      in  BITSIZE*N_IN*N_OUT   weights, w[j][i] at [(j*N_IN+i)*BITSIZE +: BITSIZE]
//   b      in  BITSIZE*N_OUT        bias, element j at [j*BITSIZE +: BITSIZE]
//   busy   out 1                    a run is in progress (MAC/BIAS/DONE)
//   done   out 1                    one-cycle pulse, all outputs written
//   valid  out 1                    y holds a complete result
//   y      out BITSIZE*N_OUT        result register bank
module enc_mac_sequencer
    import enc_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int N_IN    = 10,
    parameter int N_OUT   = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BITSIZE*N_IN-1:0]    x,
    input  logic [BITSIZE*N_IN*N_OUT-1:0] w,
    input  logic [BITSIZE*N_OUT-1:0]   b,
    output logic                       busy,
    output logic                       done,
    output logic                       valid,
    output logic [BITSIZE*N_OUT-1:0]   y
);

    localparam int IW = ctr_width(N_IN);
    localparam int JW = ctr_width(N_OUT);
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

    state_e             state_q, state_d;
    logic [IW-1:0]      i_q, i_d;
    logic [JW-1:0]      j_q, j_d;
    logic [BITSIZE-1:0] acc_q, acc_d;
    logic               valid_q, valid_d;
    logic               load_en;
    logic               y_we;

    // Operand copies so the caller may change x/w/b once a run has started
    logic [BITSIZE-1:0] x_q [N_IN];
    logic [BITSIZE-1:0] w_q [N_OUT][N_IN];
    logic [BITSIZE-1:0] b_q [N_OUT];
    logic [BITSIZE-1:0] y_q [N_OUT];

    logic [BITSIZE-1:0] mac_a, mac_b, mac_res, y_new;

    // Outside MAC the multiplier sees zeros, so the slice passes acc through
    // unchanged; BIAS relies on this to add b_j with the second adder below.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (state_q == MAC) begin
            mac_a = x_q[i_q];
            mac_b = w_q[j_q][i_q];
        end
    end

    enc_mac_unit #(.BITSIZE(BITSIZE)) u_mac (
        .a      (mac_a),
        .b      (mac_b),
        .c      (acc_q),
        .result (mac_res)
    );

    fixed_point_add #(.BITSIZE(BITSIZE)) u_bias_add (
        .a      (mac_res),
        .b      (b_q[j_q]),
        .result (y_new)
    );

    // Next-state logic: walks i within an output, then closes the output with
    // a bias cycle; valid rises together with the DONE pulse.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        load_en = 1'b0;
        y_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                    valid_d = 1'b0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = mac_res;
                if (i_q == I_LAST) begin
                    state_d = BIAS;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            BIAS: begin
                y_we  = 1'b1;
                acc_d = '0;
                i_d   = '0;
                if (j_q == J_LAST) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = MAC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, operand capture and the y bank; reset clears it all
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                x_q[i] <= '0;
            end
            for (int j = 0; j < N_OUT; j++) begin
                b_q[j] <= '0;
                y_q[j] <= '0;
                for (int i = 0; i < N_IN; i++) begin
                    w_q[j][i] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            if (load_en) begin
                for (int i = 0; i < N_IN; i++) begin
                    x_q[i] <= x[i*BITSIZE +: BITSIZE];
                end
                for (int j = 0; j < N_OUT; j++) begin
                    b_q[j] <= b[j*BITSIZE +: BITSIZE];
                    for (int i = 0; i < N_IN; i++) begin
                        w_q[j][i] <= w[(j*N_IN+i)*BITSIZE +: BITSIZE];
                    end
                end
            end
            if (y_we) begin
                y_q[j_q] <= y_new;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_y
        assign y[g*BITSIZE +: BITSIZE] = y_q[g];
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign valid = valid_q;

endmodule

// File: tb/tb_enc_mac_sequencer.sv
// Bench for enc_mac_sequencer: a cycle-level reference model built from the
// run timing (accept edge, per-output bias edge, done cycle) and plain integer
// Q8.8 arithmetic, a per-cycle compare process, and directed scenarios with
// hand-computed literal results.
module tb_enc_mac_sequencer;

    localparam int BITSIZE = 16;
    localparam int N_IN    = 10;
    localparam int N_OUT   = 6;
    localparam int DONE_AT = N_OUT * (N_IN + 1) + 1;

    logic                          clk;
    logic                          reset;
    logic                          start;
    logic [BITSIZE*N_IN-1:0]       x;
    logic [BITSIZE*N_IN*N_OUT-1:0] w;
    logic [BITSIZE*N_OUT-1:0]      b;
    logic                          busy;
    logic                          done;
    logic                          valid;
    logic [BITSIZE*N_OUT-1:0]      y;

    int checks  = 0;
    int errors  = 0;
    bit checkEn = 0;

    enc_mac_sequencer #(
        .BITSIZE (BITSIZE),
        .N_IN    (N_IN),
        .N_OUT   (N_OUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .w     (w),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q8.8 reference arithmetic on plain integers
    function automatic logic [15:0] qmul(input logic [15:0] p, input logic [15:0] q);
        int r;
        r = int'($signed(p)) * int'($signed(q));
        r = r >>> 8;
        return r[15:0];
    endfunction

    function automatic logic [15:0] qadd(input logic [15:0] p, input logic [15:0] q);
        int s;
        s = int'(p) + int'(q);
        return s[15:0];
    endfunction

    // Reference model: results computed whole at accept time, y_j revealed
    // after output j's bias edge, done/valid derived from cycles since accept
    bit          mRun     = 0;
    int          mElapsed = 0;
    bit          mValid   = 0;
    logic [15:0] mRes [N_OUT];
    logic [15:0] mY   [N_OUT];

    initial begin
        for (int j = 0; j < N_OUT; j++) begin
            mY[j]   = '0;
            mRes[j] = '0;
        end
        forever begin
            @(posedge clk);
            if (reset) begin
                mRun = 0;
                mElapsed = 0;
                mValid = 0;
                for (int j = 0; j < N_OUT; j++) mY[j] = '0;
            end else if (mRun) begin
                if (mElapsed == DONE_AT) begin
                    mRun = 0;
                    mElapsed = 0;
                end else begin
                    mElapsed++;
                    for (int j = 0; j < N_OUT; j++)
                        if (mElapsed == (j + 1) * (N_IN + 1) + 1) mY[j] = mRes[j];
                    if (mElapsed == DONE_AT) mValid = 1;
                end
            end else if (start) begin
                for (int j = 0; j < N_OUT; j++) begin
                    logic [15:0] acc;
                    acc = '0;
                    for (int i = 0; i < N_IN; i++)
                        acc = qadd(acc, qmul(x[i*16 +: 16], w[(j*N_IN+i)*16 +: 16]));
                    mRes[j] = qadd(acc, b[j*16 +: 16]);
                end
                mRun = 1;
                mElapsed = 1;
                mValid = 0;
            end
        end
    end

    // Per-cycle compare against the model, sampled mid-cycle
    int printed = 0;
    initial begin
        logic [BITSIZE*N_OUT-1:0] yExp;
        forever begin
            @(negedge clk);
            if (checkEn) begin
                for (int j = 0; j < N_OUT; j++) yExp[j*16 +: 16] = mY[j];
                checks += 4;
                if (busy !== mRun) begin
                    errors++;
                    if (printed++ < 30) $display("[TB] FAIL model_busy t=%0t got %b want %b", $time, busy, mRun);
                end
                if (done !== (mRun && mElapsed == DONE_AT)) begin
                    errors++;
                    if (printed++ < 30) $display("[TB] FAIL model_done t=%0t got %b want %b", $time, done, (mRun && mElapsed == DONE_AT));
                end
                if (valid !== mValid) begin
                    errors++;
                    if (printed++ < 30) $display("[TB] FAIL model_valid t=%0t got %b want %b", $time, valid, mValid);
                end
                if (y !== yExp) begin
                    errors++;
                    if (printed++ < 30) $display("[TB] FAIL model_y t=%0t got %h want %h", $time, y, yExp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Load operands and hold start for exactly the accept edge
    task automatic applyStimulus(input logic [BITSIZE*N_IN-1:0] xv,
                                 input logic [BITSIZE*N_IN*N_OUT-1:0] wv,
                                 input logic [BITSIZE*N_OUT-1:0] bv);
        x = xv;
        w = wv;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycles from the accept edge until done is seen (first sample counts 1)
    task automatic waitDone(output int n);
        n = 1;
        while (!done && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    function automatic logic [BITSIZE*N_IN*N_OUT-1:0] fillW(input logic [15:0] v);
        logic [BITSIZE*N_IN*N_OUT-1:0] r;
        for (int k = 0; k < N_IN * N_OUT; k++) r[k*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [BITSIZE*N_IN-1:0] fillX(input logic [15:0] v);
        logic [BITSIZE*N_IN-1:0] r;
        for (int k = 0; k < N_IN; k++) r[k*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [BITSIZE*N_OUT-1:0] fillY(input logic [15:0] base, input logic [15:0] step);
        logic [BITSIZE*N_OUT-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[k*16 +: 16] = base + 16'(k) * step;
        return r;
    endfunction

    initial begin
        int n;
        int m;
        int extraDone;
        logic [BITSIZE*N_IN-1:0] xr;

        reset = 1'b1;
        start = 1'b0;
        x = '0;
        w = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #2 checkEn = 1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_valid", 128'(valid), 128'(0));
        checkOutput("reset_y", 128'(y), 128'(0));

        // Zero weights, bias j.0: y_j = j.0, done 67 cycles after accept
        for (int k = 0; k < N_IN; k++) xr[k*16 +: 16] = 16'($urandom);
        applyStimulus(xr, fillW(16'h0000), fillY(16'h0000, 16'h0100));
        waitDone(n);
        checkOutput("t1_latency", 128'(n), 128'(67));
        @(posedge clk);
        #1;
        checkOutput("t1_y", 128'(y), 128'(fillY(16'h0000, 16'h0100)));
        checkOutput("t1_valid", 128'(valid), 128'(1));

        // x=1.0, w=0.5, b=0: ten halves sum to 5.0
        applyStimulus(fillX(16'h0100), fillW(16'h0080), '0);
        waitDone(n);
        @(posedge clk);
        #1;
        checkOutput("t2_y", 128'(y), 128'(fillY(16'h0500, 16'h0000)));

        // Operands and start churn during the run; first operands must win
        applyStimulus(fillX(16'h0200), fillW(16'h0040), fillY(16'h0000, 16'h0010));
        n = 1;
        start = 1'b1;
        while (!done && n < 200) begin
            @(posedge clk);
            #1 n++;
            if (done) begin
                start = 1'b0;
            end else begin
                for (int k = 0; k < N_IN; k++) x[k*16 +: 16] = 16'($urandom);
                for (int k = 0; k < N_IN * N_OUT; k++) w[k*16 +: 16] = 16'($urandom);
                for (int k = 0; k < N_OUT; k++) b[k*16 +: 16] = 16'($urandom);
            end
        end
        start = 1'b0;
        checkOutput("t3_latency", 128'(n), 128'(67));
        extraDone = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done) extraDone++;
        end
        checkOutput("t3_single_done", 128'(extraDone), 128'(0));
        checkOutput("t3_y", 128'(y), 128'(fillY(16'h0500, 16'h0010)));

        // Reset in the middle of a run, then a clean rerun
        applyStimulus(fillX(16'h0100), fillW(16'h0080), '0);
        repeat (29) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("t4_busy", 128'(busy), 128'(0));
        checkOutput("t4_valid", 128'(valid), 128'(0));
        checkOutput("t4_y", 128'(y), 128'(0));
        applyStimulus(fillX(16'h0100), fillW(16'h0080), '0);
        waitDone(n);
        checkOutput("t4_latency", 128'(n), 128'(67));
        @(posedge clk);
        #1;
        checkOutput("t4_rerun_y", 128'(y), 128'(fillY(16'h0500, 16'h0000)));

        // Back-to-back runs with start held; wrapping products 127*127
        x = fillX(16'h7F00);
        w = fillW(16'h7F00);
        b = '0;
        start = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!done && n < 200);
        m = 0;
        do begin
            @(posedge clk);
            #1 m++;
        end while (!done && m < 200);
        start = 1'b0;
        checkOutput("t5_spacing", 128'(m), 128'(68));
        @(posedge clk);
        #1;
        checkOutput("t5_y", 128'(y), 128'(fillY(16'h0A00, 16'h0000)));
        checkOutput("t5_valid", 128'(valid), 128'(1));

        // Random signed operands, checked by the model only
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N_IN; k++) xr[k*16 +: 16] = 16'($urandom);
            for (int k = 0; k < N_IN * N_OUT; k++) w[k*16 +: 16] = 16'($urandom);
            for (int k = 0; k < N_OUT; k++) b[k*16 +: 16] = 16'($urandom);
            applyStimulus(xr, w, b);
            waitDone(n);
            checkOutput("t6_latency", 128'(n), 128'(67));
            repeat (2) @(posedge clk);
            #1;
        end

        checkEn = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
